// File: rtl/mul_seq_if.sv
// Caller-side handshake bundle for the sequential multiplier.
// The caller holds the master modport; the multiplier holds the slave.
interface mul_seq_if;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, op_a, op_b,
        input  busy, done, product
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, product
    );
endinterface

// File: rtl/mul_seq.sv
// Unsigned 8x8->16 shift-and-add multiplier that borrows the CPU ALU.
// One iteration = ADD, rotate hi through carry, rotate lo through carry.
module mul_seq #(
    parameter bit SAVE_FLAGS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_seq_if.slave   bus,
    output logic       alu_req,
    input  logic       alu_gnt,
    output logic [1:0] alu_op_type,
    output logic [1:0] alu_arith_sel,
    output logic [1:0] alu_logic_sel,
    output logic [3:0] alu_shift_sel,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    input  logic [7:0] alu_result,
    input  logic       alu_flag_z,
    input  logic       alu_flag_c,
    input  logic       alu_flag_n,
    input  logic       alu_flag_v,
    output logic [3:0] alu_flag_din,
    output logic       alu_flag_wr
);

    localparam logic [1:0] ALU_MOVE  = 2'b00;
    localparam logic [1:0] ALU_ARITH = 2'b01;
    localparam logic [1:0] ALU_SHIFT = 2'b11;
    localparam logic [1:0] SHIFT_ROR = 2'b01;
    localparam int Z_FLAG = 3;
    localparam int C_FLAG = 2;
    localparam int N_FLAG = 1;
    localparam int V_FLAG = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADD,
        S_RRC_HI,
        S_RRC_LO,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] mcand_q, mcand_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] sflags_q, sflags_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       req_q, req_d;
    logic [3:0] flags_in;

    always_comb begin
        flags_in         = 4'b0;
        flags_in[Z_FLAG] = alu_flag_z;
        flags_in[C_FLAG] = alu_flag_c;
        flags_in[N_FLAG] = alu_flag_n;
        flags_in[V_FLAG] = alu_flag_v;
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        sflags_d = sflags_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.op_a;
                    lo_d    = bus.op_b;
                    hi_d    = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (alu_gnt) begin
                    sflags_d = flags_in;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                hi_d    = alu_result;
                state_d = S_RRC_HI;
            end
            S_RRC_HI: begin
                hi_d    = alu_result;
                state_d = S_RRC_LO;
            end
            S_RRC_LO: begin
                lo_d  = alu_result;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7)
                    state_d = SAVE_FLAGS ? S_RESTORE : S_DONE;
                else
                    state_d = S_ADD;
            end
            S_RESTORE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        req_d  = (state_d inside {S_REQ, S_ADD, S_RRC_HI,
                                  S_RRC_LO, S_RESTORE});
    end

    // ALU is driven only while we own it; otherwise MOVE keeps flags intact.
    always_comb begin
        alu_op_type   = ALU_MOVE;
        alu_arith_sel = 2'b00;
        alu_logic_sel = 2'b00;
        alu_shift_sel = 4'b0000;
        alu_operand1  = 8'h00;
        alu_operand2  = 8'h00;
        alu_flag_din  = 4'b0000;
        alu_flag_wr   = 1'b0;
        unique case (state_q)
            S_ADD: begin
                alu_op_type  = ALU_ARITH;
                alu_operand1 = hi_q;
                alu_operand2 = lo_q[0] ? mcand_q : 8'h00;
            end
            S_RRC_HI: begin
                alu_op_type   = ALU_SHIFT;
                alu_shift_sel = {1'b0, 1'b1, SHIFT_ROR};
                alu_operand1  = hi_q;
            end
            S_RRC_LO: begin
                alu_op_type   = ALU_SHIFT;
                alu_shift_sel = {1'b0, 1'b1, SHIFT_ROR};
                alu_operand1  = lo_q;
            end
            S_RESTORE: begin
                alu_flag_wr  = 1'b1;
                alu_flag_din = sflags_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hi_q     <= 8'h00;
            lo_q     <= 8'h00;
            mcand_q  <= 8'h00;
            cnt_q    <= 3'd0;
            sflags_q <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            sflags_q <= sflags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = {hi_q, lo_q};
    assign alu_req     = req_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench: two multipliers (flag restore on/off) with ALU models.
// Stimulus pushes expected product/latency; monitors pop on done.
module tb_mul_seq;

  localparam logic [1:0] ALU_MOVE  = 2'b00;
  localparam logic [1:0] ALU_ARITH = 2'b01;
  localparam logic [1:0] ALU_SHIFT = 2'b11;
  localparam logic [3:0] SEL_RRC   = 4'b0101;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  mul_seq_if u_if0();
  mul_seq_if u_if1();

  logic       a_req  [2];
  logic       a_gnt  [2];
  logic [1:0] a_ot   [2];
  logic [1:0] a_as   [2];
  logic [1:0] a_ls   [2];
  logic [3:0] a_ss   [2];
  logic [7:0] a_o1   [2];
  logic [7:0] a_o2   [2];
  logic [7:0] a_res  [2];
  logic [8:0] a_ev   [2];
  logic       fz     [2];
  logic       fc     [2];
  logic       fn     [2];
  logic       fv     [2];
  logic [3:0] a_fdin [2];
  logic       a_fwr  [2];

  logic       preset_en;
  logic [3:0] preset_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq #(.SAVE_FLAGS(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if0.slave),
    .alu_req(a_req[0]), .alu_gnt(a_gnt[0]),
    .alu_op_type(a_ot[0]), .alu_arith_sel(a_as[0]),
    .alu_logic_sel(a_ls[0]), .alu_shift_sel(a_ss[0]),
    .alu_operand1(a_o1[0]), .alu_operand2(a_o2[0]),
    .alu_result(a_res[0]),
    .alu_flag_z(fz[0]), .alu_flag_c(fc[0]),
    .alu_flag_n(fn[0]), .alu_flag_v(fv[0]),
    .alu_flag_din(a_fdin[0]), .alu_flag_wr(a_fwr[0])
  );

  mul_seq #(.SAVE_FLAGS(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1.slave),
    .alu_req(a_req[1]), .alu_gnt(a_gnt[1]),
    .alu_op_type(a_ot[1]), .alu_arith_sel(a_as[1]),
    .alu_logic_sel(a_ls[1]), .alu_shift_sel(a_ss[1]),
    .alu_operand1(a_o1[1]), .alu_operand2(a_o2[1]),
    .alu_result(a_res[1]),
    .alu_flag_z(fz[1]), .alu_flag_c(fc[1]),
    .alu_flag_n(fn[1]), .alu_flag_v(fv[1]),
    .alu_flag_din(a_fdin[1]), .alu_flag_wr(a_fwr[1])
  );

  function automatic logic [8:0] alu_eval(
    input logic [1:0] ot, input logic [1:0] as,
    input logic [3:0] ss, input logic [7:0] a,
    input logic [7:0] b, input logic c);
    logic [8:0] r;
    r = {1'b0, b};
    if (ot == ALU_ARITH) begin
      r = {1'b0, a} + {1'b0, b};
      if (as == 2'b01) r = r + 9'd1 * c;
    end else if (ot == ALU_SHIFT && ss == SEL_RRC) begin
      r = {a[0], c, a[7:1]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_ev[i]  = alu_eval(a_ot[i], a_as[i], a_ss[i],
                          a_o1[i], a_o2[i], fc[i]);
      a_res[i] = a_ev[i][7:0];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preset_en) begin
        {fz[i], fc[i], fn[i], fv[i]} <= preset_val;
      end else if (a_fwr[i]) begin
        {fz[i], fc[i], fn[i], fv[i]} <= a_fdin[i];
      end else if (a_ot[i] == ALU_ARITH) begin
        fc[i] <= a_ev[i][8];
        fz[i] <= (a_ev[i][7:0] == 8'h00);
        fn[i] <= a_ev[i][7];
        fv[i] <= (a_o1[i][7] == a_o2[i][7]) &&
                 (a_ev[i][7] != a_o1[i][7]);
      end else if (a_ot[i] == ALU_SHIFT) begin
        fc[i] <= a_ev[i][8];
        fz[i] <= (a_ev[i][7:0] == 8'h00);
        fn[i] <= a_ev[i][7];
        fv[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && u_if0.done === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("dut0_product", {16'h0, u_if0.product}, {16'h0, e.prod});
        chk("dut0_latency", cyc - e.t0, e.lat);
      end
    end
    if (rst_n === 1'b1 && u_if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dut1_product", {16'h0, u_if1.product}, {16'h0, e.prod});
        chk("dut1_latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic issue(input int k, input logic [7:0] a,
                       input logic [7:0] b, input int lat,
                       input logic [15:0] p);
    exp_t e;
    @(negedge clk);
    e.prod = p;
    e.lat  = lat;
    e.t0   = cyc;
    if (k == 0) begin
      u_if0.start = 1'b1;
      u_if0.op_a  = a;
      u_if0.op_b  = b;
      q0.push_back(e);
    end else begin
      u_if1.start = 1'b1;
      u_if1.op_a  = a;
      u_if1.op_b  = b;
      q1.push_back(e);
    end
    @(negedge clk);
    u_if0.start = 1'b0;
    u_if1.start = 1'b0;
  endtask

  task automatic wait_q(input int k);
    int n = 0;
    while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (((k == 0) ? q0.size() : q1.size()) != 0)
      chk("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    preset_en   = 1'b1;
    preset_val  = 4'b1101;
    a_gnt[0]    = 1'b1;
    a_gnt[1]    = 1'b1;
    u_if0.start = 1'b0;
    u_if0.op_a  = 8'h00;
    u_if0.op_b  = 8'h00;
    u_if1.start = 1'b0;
    u_if1.op_a  = 8'h00;
    u_if1.op_b  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, u_if0.busy}, 32'd0);
    chk("rst_done", {31'b0, u_if0.done}, 32'd0);
    chk("rst_product", {16'h0, u_if0.product}, 32'd0);
    chk("rst_req", {31'b0, a_req[0]}, 32'd0);
    chk("rst_optype", {30'b0, a_ot[0]}, {30'b0, ALU_MOVE});
    chk("rst_flag_wr", {31'b0, a_fwr[0]}, 32'd0);
    rst_n     = 1'b1;
    preset_en = 1'b0;

    // 13*11 with flags Z=1 C=1 N=0 V=1 preset
    issue(0, 8'd13, 8'd11, 27, 16'h008F);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      chk("seq_optype", {30'b0, a_ot[0]},
          {30'b0, (j % 3 == 0) ? ALU_ARITH : ALU_SHIFT});
      if (j == 0) chk("first_add_op2", {24'b0, a_o2[0]}, 32'd13);
      if (j == 1) chk("rrc_shift_sel", {28'b0, a_ss[0]}, {28'b0, SEL_RRC});
    end
    @(negedge clk);
    chk("restore_flag_wr", {31'b0, a_fwr[0]}, 32'd1);
    wait_q(0);
    chk("restored_flags", {28'b0, fz[0], fc[0], fn[0], fv[0]}, 32'hD);

    issue(0, 8'hFF, 8'hFF, 27, 16'hFE01);
    wait_q(0);
    issue(0, 8'h00, 8'hA5, 27, 16'h0000);
    wait_q(0);

    // no flag restore: done one cycle earlier, flags from final RRC
    issue(1, 8'd13, 8'd11, 26, 16'h008F);
    wait_q(1);
    chk("noSave_flags", {28'b0, fz[1], fc[1], fn[1], fv[1]}, 32'h2);

    // grant withheld for five REQ cycles
    a_gnt[0] = 1'b0;
    issue(0, 8'd200, 8'd3, 32, 16'd600);
    for (int j = 0; j < 6; j++) begin
      chk("req_held", {31'b0, a_req[0]}, 32'd1);
      chk("req_idle_drive", {a_ot[0], a_o1[0], a_o2[0], 7'b0, a_fwr[0]}, 32'd0);
      if (j < 5) @(negedge clk);
    end
    a_gnt[0] = 1'b1;
    wait_q(0);

    // starts during ADD and in the DONE cycle are ignored
    issue(0, 8'd6, 8'd7, 27, 16'h002A);
    @(negedge clk);
    u_if0.start = 1'b1;
    u_if0.op_a  = 8'hFF;
    u_if0.op_b  = 8'hFF;
    @(negedge clk);
    u_if0.start = 1'b0;
    n = 0;
    while (u_if0.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t5_done_seen", {31'b0, u_if0.done}, 32'd1);
    u_if0.start = 1'b1;
    u_if0.op_a  = 8'd3;
    u_if0.op_b  = 8'd3;
    @(negedge clk);
    u_if0.start = 1'b0;
    chk("t5_busy_after", {31'b0, u_if0.busy}, 32'd0);
    chk("t5_product_held", {16'h0, u_if0.product}, 32'h2A);
    repeat (35) @(negedge clk);
    chk("t5_still_idle", {31'b0, u_if0.busy}, 32'd0);

    // reset during iteration 4
    issue(0, 8'd200, 8'd200, 27, 16'd40000);
    repeat (10) @(negedge clk);
    chk("t6_busy_mid", {31'b0, u_if0.busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    q0.delete();
    chk("t6_busy", {31'b0, u_if0.busy}, 32'd0);
    chk("t6_req", {31'b0, a_req[0]}, 32'd0);
    chk("t6_product", {16'h0, u_if0.product}, 32'd0);
    chk("t6_flag_wr", {31'b0, a_fwr[0]}, 32'd0);
    rst_n = 1'b1;
    issue(0, 8'd7, 8'd9, 27, 16'h003F);
    wait_q(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b0 && a_fwr[0] === 1'b1)
      chk("flag_wr_in_reset", 32'd1, 32'd0);
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle unsigned 8x8->16 multiply sequencer that drives the CPU ALU over its control, operand and flag ports using shift-and-add.
- Sits beside the ALU behind the ALU-ownership arbiter. It requests the ALU, runs 8 iterations of ADD / RRC-hi / RRC-lo, then optionally restores the caller's ALU flags.
- Delivers a 16-bit product with a one-cycle done pulse.

Parameters:
SAVE_FLAGS, 1, 1 = capture ALU Z/C/N/V at grant and write them back after the last iteration; 0 = flags are left clobbered.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  one-cycle request to start a multiply; sampled only in IDLE
op_a  input  8  multiplicand, latched on accepted start
op_b  input  8  multiplier, latched on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; product valid from this cycle until the next accepted start
product  output  16  {hi, lo} result register
alu_req  output  1  ALU ownership request to arbiter
alu_gnt  input  1  ALU ownership grant
alu_op_type  output  2  to ALU op_type
alu_arith_sel  output  2  to ALU arith_sel
alu_logic_sel  output  2  to ALU logic_sel, constant 0
alu_shift_sel  output  4  to ALU shift_sel
alu_operand1  output  8  to ALU operand1
alu_operand2  output  8  to ALU operand2
alu_result  input  8  ALU result (combinational from operands)
alu_flag_z, alu_flag_c, alu_flag_n, alu_flag_v  input  1 each  ALU registered flags
alu_flag_din  output  4  to ALU flag_din, packed by the Z_FLAG/C_FLAG/N_FLAG/V_FLAG bit indices
alu_flag_wr  output  1  to ALU flag_wr

Behaviour:
- Reset (rst_n=0 at edge), including mid-operation:
  - State -> IDLE; hi, lo, mcand, cnt, saved flags -> 0.
  - busy=0, done=0, alu_req=0, alu_flag_wr=0.
  - ALU outputs at idle values. Flags are NOT restored on reset.
- Idle ALU drive (every state except ADD/RRC_HI/RRC_LO/RESTORE):
  - op_type=ALU_MOVE, arith_sel=0, shift_sel=0, operands=0, flag_din=0, flag_wr=0.
  - ALU_MOVE guarantees no flag update.
- IDLE:
  - start=1 -> latch mcand=op_a, lo=op_b, hi=0, cnt=0; go to REQ.
  - start while busy is ignored.
- REQ:
  - alu_req=1.
  - alu_gnt=0 -> stay.
  - alu_gnt=1 -> capture {Z,C,N,V} into saved flags; go to ADD.
  - The arbiter must hold the grant until alu_req falls; alu_gnt is not re-sampled after REQ.
- ADD:
  - Drive op_type=ALU_ARITH, arith_sel=2'b00 (add, no carry), operand1=hi, operand2 = lo[0] ? mcand : 8'h00.
  - At edge: hi <= alu_result. The ALU latches carry-out into C (C=0 when operand2=0).
  - Go to RRC_HI.
- RRC_HI:
  - Drive op_type=ALU_SHIFT, shift_sel={1'b0,1'b1,SHIFT_ROR} (rotate right through carry), operand1=hi.
  - At edge: hi <= alu_result = {C, hi[7:1]}. The ALU latches C=old hi[0].
  - Go to RRC_LO.
- RRC_LO:
  - Same controls, operand1=lo.
  - At edge: lo <= {C, lo[7:1]}; cnt <= cnt+1.
  - cnt==7 -> go to RESTORE if SAVE_FLAGS, else DONE; otherwise go to ADD.
- RESTORE:
  - alu_flag_wr=1, alu_flag_din=saved flags, op_type=ALU_MOVE.
  - Go to DONE.
- DONE:
  - done=1, alu_req=0; go to IDLE.
  - A start in this cycle is ignored.
- alu_req is 1 in REQ through RESTORE inclusive.
- cnt is 3 bits; it never wraps within an operation.
- Latency with grant already high at REQ:
  - start accepted at cycle 0 -> REQ at 1, iterations at cycles 2..25, RESTORE at 26.
  - done at cycle 27 (SAVE_FLAGS=1), or 26 (SAVE_FLAGS=0).
- Each extra cycle of grant delay adds 1 cycle.
- product = {hi, lo}. It holds its value after DONE and is overwritten only by the next accepted start: hi=0, lo=op_b at that point.

Test Plan:
1. op_a=13, op_b=11, grant tied high -> done exactly 27 cycles after start, product=16'h008F; 24 ALU cycles follow the ADD/RRC_HI/RRC_LO order.
2. op_a=8'hFF, op_b=8'hFF -> product=16'hFE01; carries propagate correctly on every iteration. op_a=0, op_b=8'hA5 -> product=0.
3. Preset ALU flags Z=1, C=1, N=0, V=1, SAVE_FLAGS=1 -> at completion ALU flags again Z=1, C=1, N=0, V=1; with SAVE_FLAGS=0 done comes at cycle 26 and flags reflect the final RRC.
4. alu_gnt held low 5 cycles after start -> alu_req=1 and ALU outputs remain at ALU_MOVE/0 throughout; done arrives at cycle 32; product still correct.
5. start pulsed again during ADD and in the DONE cycle -> ignored; operands unchanged, a single done pulse.
6. rst_n=0 during iteration 4 -> next cycle busy=0, alu_req=0, product=0, alu_flag_wr never asserted; a new start afterwards computes 7*9=16'h003F.
